// File: rtl/router_fifo_if.sv
// Handshake and data bus between the router write side, the destination
// client and one per-destination output FIFO.
interface router_fifo_if #(
    parameter int WIDTH = 8
);
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             pkt_done;

    // Router / client side: drives requests and data, observes status.
    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, full, empty, pkt_done
    );

    // FIFO side.
    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, full, empty, pkt_done
    );
endinterface

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router. Each entry carries a
// header tag so the read side can load the packet length and blank the
// output once header, payload and parity have all been read.
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          soft_reset,
    router_fifo_if.slave  bus
);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH:0] mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [5:0]     pkt_cnt;
    logic           lfd_q;
    logic           do_wr;
    logic           do_rd;
    logic [WIDTH:0] rd_word;
    logic [5:0]     hdr_len;

    // Status comes straight from the pointers; the wrap bit separates full from empty.
    assign bus.empty = (wr_ptr == rd_ptr);
    assign bus.full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Status is evaluated before the edge, so a full FIFO drops a
    // same-cycle write and an empty FIFO ignores a same-cycle read.
    assign do_wr   = bus.write_enb && !bus.full;
    assign do_rd   = bus.read_enb && !bus.empty;
    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign hdr_len = rd_word[WIDTH-1 -: 6];

    // lfd_state leads router_reg's data by one cycle; delay it so the tag lands on the header byte.
    always_ff @(posedge clk) begin
        if (reset || soft_reset)
            lfd_q <= 1'b0;
        else
            lfd_q <= bus.lfd_state;
    end

    // Write side: memory and write pointer; soft_reset keeps memory contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
        end else if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_q, bus.data_in};
            wr_ptr              <= wr_ptr + PTR_ONE;
        end
    end

    // Read side: registered data, packet length tracking and end-of-packet pulse.
    always_ff @(posedge clk) begin
        if (reset || soft_reset) begin
            rd_ptr       <= '0;
            pkt_cnt      <= '0;
            bus.data_out <= '0;
            bus.pkt_done <= 1'b0;
        end else begin
            bus.pkt_done <= 1'b0;
            if (do_rd)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (do_rd && rd_word[WIDTH]) begin
                // Header: remaining = payload length plus the parity byte.
                bus.data_out <= rd_word[WIDTH-1:0];
                pkt_cnt      <= hdr_len + 6'd1;
            end else if (do_rd && pkt_cnt != 6'd0) begin
                bus.data_out <= rd_word[WIDTH-1:0];
                pkt_cnt      <= pkt_cnt - 6'd1;
                bus.pkt_done <= (pkt_cnt == 6'd1);
            end else if (pkt_cnt == 6'd0) begin
                // Outside a packet nothing stale is presented.
                bus.data_out <= '0;
            end
        end
    end
endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed packet scenarios plus a
// randomized phase, all compared against a queue-based packet model.
module tb_router_fifo;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic soft_reset = 1'b0;

    router_fifo_if #(.WIDTH(8)) bus ();

    router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: stored entries as {tag, byte}, bytes left in the packet being read.
    logic [8:0] q[$];
    int         left;
    bit         lfd_prev;
    logic [7:0] exp_dout;
    bit         exp_done;

    task automatic model_clear();
        q.delete();
        left     = 0;
        lfd_prev = 0;
        exp_dout = 8'h00;
        exp_done = 0;
    endtask

    // One clock: drive inputs, advance the model by the packet rules, settle past the edge.
    task automatic step(input bit we, input bit re, input bit lfd, input logic [7:0] din, input bit sr = 0);
        bit fm, em;
        logic [8:0] e;
        fm = (q.size() == 16);
        em = (q.size() == 0);
        bus.write_enb = we;
        bus.read_enb  = re;
        bus.lfd_state = lfd;
        bus.data_in   = din;
        soft_reset    = sr;
        @(posedge clk);
        if (sr) begin
            model_clear();
        end else begin
            exp_done = 0;
            if (re && !em) begin
                e = q.pop_front();
                if (e[8]) begin
                    exp_dout = e[7:0];
                    left     = (int'(e[7:2]) + 1) % 64;
                end else if (left > 0) begin
                    exp_dout = e[7:0];
                    left--;
                    exp_done = (left == 0);
                end else begin
                    exp_dout = 8'h00;
                end
            end else if (left == 0) begin
                exp_dout = 8'h00;
            end
            if (we && !fm)
                q.push_back({lfd_prev, din});
            lfd_prev = lfd;
        end
        #1;
        bus.write_enb = 0;
        bus.read_enb  = 0;
        bus.lfd_state = 0;
        soft_reset    = 0;
    endtask

    task automatic do_reset();
        bus.write_enb = 0;
        bus.read_enb  = 0;
        bus.lfd_state = 0;
        bus.data_in   = 8'h00;
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;
        model_clear();
    endtask

    // Writes a packet: a cycle with lfd_state high, then header, payload, parity.
    task automatic write_pkt(input logic [7:0] hdr, input logic [7:0] parity);
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, hdr);
        for (int i = 0; i < int'(hdr[7:2]); i++)
            step(1, 0, 0, 8'($urandom));
        step(1, 0, 0, parity);
    endtask

    task automatic test_reset();
        do_reset();
        step(0, 0, 0, 8'h00);
        total++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.data_out !== 8'h00 || bus.pkt_done !== 1'b0) begin
            bad++;
            $display("FAIL reset empty=%b full=%b dout=%h done=%b want 1 0 00 0",
                     bus.empty, bus.full, bus.data_out, bus.pkt_done);
        end
    endtask

    task automatic test_packet();
        int dones;
        do_reset();
        write_pkt(8'h22, 8'h09);
        total++;
        if (bus.empty !== 1'b0 || bus.full !== 1'b0 || q.size() != 10) begin
            bad++;
            $display("FAIL pkt_fill empty=%b full=%b want 0 0 (model size %0d)", bus.empty, bus.full, q.size());
        end
        dones = 0;
        for (int i = 0; i < 11; i++) begin
            step(0, 1, 0, 8'h00);
            if (exp_done) dones++;
            total++;
            if (bus.data_out !== exp_dout || bus.pkt_done !== exp_done || bus.empty !== (q.size() == 0)) begin
                bad++;
                $display("FAIL pkt_read[%0d] dout=%h done=%b empty=%b want %h %b %b",
                         i, bus.data_out, bus.pkt_done, bus.empty, exp_dout, exp_done, q.size() == 0);
            end
        end
        total++;
        if (dones != 1 || bus.data_out !== 8'h00) begin
            bad++;
            $display("FAIL pkt_end done_pulses=%0d dout=%h want 1 00", dones, bus.data_out);
        end
    endtask

    task automatic test_full();
        do_reset();
        write_pkt(8'h38, 8'h5c);
        total++;
        if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin
            bad++;
            $display("FAIL full_set full=%b empty=%b want 1 0", bus.full, bus.empty);
        end
        step(1, 0, 0, 8'hAA);
        total++;
        if (bus.full !== 1'b1 || q.size() != 16) begin
            bad++;
            $display("FAIL full_drop full=%b want 1", bus.full);
        end
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 0, 8'h00);
            total++;
            if (bus.data_out !== exp_dout || bus.pkt_done !== exp_done ||
                bus.empty !== (q.size() == 0) || bus.full !== (q.size() == 16)) begin
                bad++;
                $display("FAIL full_read[%0d] dout=%h done=%b empty=%b full=%b want %h %b %b %b", i,
                         bus.data_out, bus.pkt_done, bus.empty, bus.full, exp_dout, exp_done,
                         q.size() == 0, q.size() == 16);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_pkt(8'h39, 8'h11);
        step(1, 1, 0, 8'h55);
        total++;
        if (bus.full !== 1'b0 || bus.empty !== 1'b0 || bus.data_out !== 8'h39 || q.size() != 15) begin
            bad++;
            $display("FAIL rw_full full=%b empty=%b dout=%h want 0 0 39", bus.full, bus.empty, bus.data_out);
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 8'h00);
            total++;
            if (bus.data_out !== exp_dout || bus.pkt_done !== exp_done || bus.empty !== (q.size() == 0)) begin
                bad++;
                $display("FAIL rw_drain[%0d] dout=%h done=%b empty=%b want %h %b %b", i,
                         bus.data_out, bus.pkt_done, bus.empty, exp_dout, exp_done, q.size() == 0);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        write_pkt(8'h21, 8'h3c);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h00);
        // Two more packets written while reading concurrently; pointers cross the wrap point.
        for (int p = 0; p < 2; p++) begin
            step(0, 1, 1, 8'h00);
            for (int i = 0; i < 10; i++) begin
                step(1, 1, 0, (i == 0) ? 8'h22 : 8'($urandom));
                total++;
                if (bus.data_out !== exp_dout || bus.pkt_done !== exp_done ||
                    bus.empty !== (q.size() == 0) || bus.full !== (q.size() == 16)) begin
                    bad++;
                    $display("FAIL wrap[%0d.%0d] dout=%h done=%b empty=%b full=%b want %h %b %b %b", p, i,
                             bus.data_out, bus.pkt_done, bus.empty, bus.full, exp_dout, exp_done,
                             q.size() == 0, q.size() == 16);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00);
            total++;
            if (bus.data_out !== exp_dout || bus.pkt_done !== exp_done || bus.empty !== (q.size() == 0)) begin
                bad++;
                $display("FAIL wrap_drain[%0d] dout=%h done=%b empty=%b want %h %b %b", i,
                         bus.data_out, bus.pkt_done, bus.empty, exp_dout, exp_done, q.size() == 0);
            end
        end
    endtask

    task automatic test_soft_reset();
        do_reset();
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'h10);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'($urandom));
        step(1, 0, 0, 8'h77, 1);
        total++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.data_out !== 8'h00 || bus.pkt_done !== 1'b0) begin
            bad++;
            $display("FAIL soft_reset empty=%b full=%b dout=%h done=%b want 1 0 00 0",
                     bus.empty, bus.full, bus.data_out, bus.pkt_done);
        end
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'h06);
        step(1, 0, 0, 8'hc3);
        step(1, 0, 0, 8'h5a);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'h00);
            total++;
            if (bus.data_out !== exp_dout || bus.pkt_done !== exp_done || bus.empty !== (q.size() == 0)) begin
                bad++;
                $display("FAIL soft_after[%0d] dout=%h done=%b empty=%b want %h %b %b", i,
                         bus.data_out, bus.pkt_done, bus.empty, exp_dout, exp_done, q.size() == 0);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 9) < 6), bit'($urandom_range(0, 9) < 5),
                 bit'($urandom_range(0, 9) == 0), 8'($urandom), bit'($urandom_range(0, 99) == 0));
            total++;
            if (bus.data_out !== exp_dout || bus.pkt_done !== exp_done ||
                bus.empty !== (q.size() == 0) || bus.full !== (q.size() == 16)) begin
                bad++;
                $display("FAIL random[%0d] dout=%h done=%b empty=%b full=%b want %h %b %b %b", i,
                         bus.data_out, bus.pkt_done, bus.empty, bus.full, exp_dout, exp_done,
                         q.size() == 0, q.size() == 16);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_packet();
        test_full();
        test_back_to_back();
        test_wrap();
        test_soft_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
